// File: rtl/up_down_counter_pkg.sv
// Shared types and constants for the up/down count decoder.
package up_down_counter_pkg;

  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY,
    PRIMED,
    UP,
    DOWN
  } ud_state_t;

  typedef enum logic [1:0] {
    STEP_UP,
    STEP_DOWN,
    STEP_HOLD,
    STEP_ILLEGAL
  } ud_step_t;

endpackage

// File: rtl/up_down_step_classify.sv
// Combinational classifier: compares a new count sample against the
// reference sample and reports the kind of step and whether it wrapped.
module up_down_step_classify
  import up_down_counter_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_VALUE = 10
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] c,
  output ud_step_t     step,
  output logic         is_wrap
);

  // One extra bit so p+1 at 2^N-1 and p-1 at 0 never alias a legal value.
  localparam logic [N:0] MAX_EXT = (N+1)'(MAX_VALUE);

  logic [N:0] p_ext;
  logic [N:0] c_ext;
  logic [N:0] p_inc;
  logic [N:0] p_dec;

  // Successor/predecessor on the 0..MAX_VALUE loop, then priority match.
  always_comb begin
    p_ext   = {1'b0, p};
    c_ext   = {1'b0, c};
    p_inc   = (p_ext == MAX_EXT) ? '0 : p_ext + 1'b1;
    p_dec   = (p_ext == '0) ? MAX_EXT : p_ext - 1'b1;
    step    = STEP_ILLEGAL;
    is_wrap = 1'b0;
    if (c_ext > MAX_EXT) begin
      step = STEP_ILLEGAL;
    end else if (c_ext == p_ext) begin
      step = STEP_HOLD;
    end else if (c_ext == p_inc) begin
      step    = STEP_UP;
      is_wrap = (p_ext == MAX_EXT);
    end else if (c_ext == p_dec) begin
      step    = STEP_DOWN;
      is_wrap = (p_ext == '0);
    end
  end

endmodule

// File: rtl/up_down_count_decoder.sv
// Observer for a looping up/down counter: tracks direction, flags wraps,
// direction reversals and illegal samples, and tallies errors.
module up_down_count_decoder
  import up_down_counter_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_VALUE = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 sample_en,
  input  logic [N-1:0]         count_in,
  output logic                 dir,
  output logic                 dir_valid,
  output logic [N-1:0]         last_count,
  output logic                 step_pulse,
  output logic                 wrap_pulse,
  output logic                 dir_change_pulse,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [N:0] MAX_EXT = (N+1)'(MAX_VALUE);

  ud_state_t state;
  ud_step_t  step;
  logic      is_wrap;
  logic      in_range;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // The last accepted sample is the reference for the next classification.
  up_down_step_classify #(
    .N         (N),
    .MAX_VALUE (MAX_VALUE)
  ) u_classify (
    .p       (last_count),
    .c       (count_in),
    .step    (step),
    .is_wrap (is_wrap)
  );

  // Out-of-range samples can never serve as a reference.
  assign in_range = ({1'b0, count_in} <= MAX_EXT);

  // Tracking FSM with registered outputs and saturating error tally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= EMPTY;
      dir              <= 1'b0;
      dir_valid        <= 1'b0;
      last_count       <= '0;
      step_pulse       <= 1'b0;
      wrap_pulse       <= 1'b0;
      dir_change_pulse <= 1'b0;
      err_pulse        <= 1'b0;
      err_count        <= '0;
    end else begin
      step_pulse       <= 1'b0;
      wrap_pulse       <= 1'b0;
      dir_change_pulse <= 1'b0;
      err_pulse        <= 1'b0;
      if (clear) begin
        state      <= EMPTY;
        dir        <= 1'b0;
        dir_valid  <= 1'b0;
        last_count <= '0;
        err_count  <= '0;
      end else if (sample_en) begin
        if (!in_range) begin
          // No usable reference remains, from any state.
          state     <= EMPTY;
          dir_valid <= 1'b0;
          err_pulse <= 1'b1;
          err_count <= sat_inc(err_count);
        end else begin
          last_count <= count_in;
          case (state)
            EMPTY: begin
              state <= PRIMED;
            end
            default: begin
              // PRIMED, UP and DOWN share the step handling; reversal
              // is only reported when a direction was already tracked.
              case (step)
                STEP_UP: begin
                  state            <= UP;
                  dir              <= 1'b1;
                  dir_valid        <= 1'b1;
                  step_pulse       <= 1'b1;
                  wrap_pulse       <= is_wrap;
                  dir_change_pulse <= (state == DOWN);
                end
                STEP_DOWN: begin
                  state            <= DOWN;
                  dir              <= 1'b0;
                  dir_valid        <= 1'b1;
                  step_pulse       <= 1'b1;
                  wrap_pulse       <= is_wrap;
                  dir_change_pulse <= (state == UP);
                end
                STEP_ILLEGAL: begin
                  state     <= PRIMED;
                  dir_valid <= 1'b0;
                  err_pulse <= 1'b1;
                  err_count <= sat_inc(err_count);
                end
                default: begin
                  state <= state;
                end
              endcase
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_up_down_count_decoder.sv
// Randomized and directed bench for up_down_count_decoder against a
// modular-arithmetic reference model.
module tb_up_down_count_decoder;

  localparam int N = 4;
  localparam int M = 10;

  logic         clk;
  logic         reset_n;
  logic         clear;
  logic         sample_en;
  logic [N-1:0] count_in;
  logic         dir;
  logic         dir_valid;
  logic [N-1:0] last_count;
  logic         step_pulse;
  logic         wrap_pulse;
  logic         dir_change_pulse;
  logic         err_pulse;
  logic [7:0]   err_count;

  int n_checks;
  int n_errors;

  // Reference model state
  int m_have_ref;
  int m_ref;
  int m_trend;   // +1 up, -1 down, 0 unknown
  int m_dir;
  int m_last;
  int m_errs;
  int m_step, m_wrap, m_dchg, m_err;

  up_down_count_decoder #(.N(N), .MAX_VALUE(M)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .clear            (clear),
    .sample_en        (sample_en),
    .count_in         (count_in),
    .dir              (dir),
    .dir_valid        (dir_valid),
    .last_count       (last_count),
    .step_pulse       (step_pulse),
    .wrap_pulse       (wrap_pulse),
    .dir_change_pulse (dir_change_pulse),
    .err_pulse        (err_pulse),
    .err_count        (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have_ref = 0; m_ref = 0; m_trend = 0; m_dir = 0; m_last = 0; m_errs = 0;
    m_step = 0; m_wrap = 0; m_dchg = 0; m_err = 0;
  endtask

  task automatic model_error();
    m_err = 1;
    if (m_errs < 255) m_errs++;
  endtask

  task automatic model_update(input int en, input int c, input int clr);
    int delta;
    int s;
    m_step = 0; m_wrap = 0; m_dchg = 0; m_err = 0;
    if (clr != 0) begin
      model_reset();
      return;
    end
    if (en == 0) return;
    if (c > M) begin
      model_error();
      m_have_ref = 0;
      m_trend = 0;
      return;
    end
    m_last = c;
    if (m_have_ref == 0) begin
      m_have_ref = 1;
      m_ref = c;
      return;
    end
    delta = (c - m_ref + M + 1) % (M + 1);
    if (delta == 0) begin
      // hold
    end else if (delta == 1 || delta == M) begin
      s = (delta == 1) ? 1 : -1;
      m_step = 1;
      m_wrap = ((s == 1 && c == 0) || (s == -1 && c == M)) ? 1 : 0;
      m_dchg = (m_trend != 0 && m_trend != s) ? 1 : 0;
      m_trend = s;
      m_dir = (s == 1) ? 1 : 0;
    end else begin
      model_error();
      m_trend = 0;
    end
    m_ref = c;
  endtask

  task automatic check_outputs();
    chk("dir", int'(dir), m_dir);
    chk("dir_valid", int'(dir_valid), (m_trend != 0) ? 1 : 0);
    chk("last_count", int'(last_count), m_last);
    chk("step_pulse", int'(step_pulse), m_step);
    chk("wrap_pulse", int'(wrap_pulse), m_wrap);
    chk("dir_change_pulse", int'(dir_change_pulse), m_dchg);
    chk("err_pulse", int'(err_pulse), m_err);
    chk("err_count", int'(err_count), m_errs);
  endtask

  task automatic cycle(input int en, input int v, input int clr);
    @(negedge clk);
    sample_en = (en != 0);
    count_in  = N'(v);
    clear     = (clr != 0);
    model_update(en, v, clr);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, $urandom_range(0, 15), 0);
  endtask

  task automatic run_seq(input int vals[$]);
    foreach (vals[i]) cycle(1, vals[i], 0);
  endtask

  initial begin
    int k, v, en, clr;
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    clear = 1'b0;
    sample_en = 1'b0;
    count_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Up run with wrap
    run_seq('{8, 9, 10, 0, 1});
    chk("up_err_count", int'(err_count), 0);

    // Down run with wrap and reversal
    cycle(0, 0, 1);
    run_seq('{1, 0, 10, 9, 10});

    // Hold with idle gaps
    cycle(0, 0, 1);
    cycle(1, 3, 0);
    idle(5);
    cycle(1, 3, 0);
    idle(5);
    cycle(1, 4, 0);
    chk("hold_up_dir_valid", int'(dir_valid), 1);

    // Illegal jump while tracking up
    cycle(0, 0, 1);
    run_seq('{4, 5, 9});
    chk("ill_dir_valid", int'(dir_valid), 0);
    chk("ill_last", int'(last_count), 9);
    cycle(1, 10, 0);
    chk("ill_recover_dir_valid", int'(dir_valid), 1);

    // Out of range from EMPTY, then saturation
    cycle(0, 0, 1);
    cycle(1, 14, 0);
    for (int i = 0; i < 300; i++) cycle(1, (i % 2 == 0) ? 15 : 14, 0);
    chk("err_saturated", int'(err_count), 255);
    cycle(1, 5, 1);
    chk("clear_err_count", int'(err_count), 0);
    cycle(1, 6, 0);
    chk("after_clear_no_step", int'(step_pulse), 0);

    // Asynchronous reset while tracking down
    run_seq('{5, 4, 3});
    @(posedge clk);
    #3;
    sample_en = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1, 2, 0);
    cycle(1, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      clr = ($urandom_range(0, 99) < 2) ? 1 : 0;
      en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      k   = $urandom_range(0, 9);
      if (k <= 3)      v = (m_ref + 1) % (M + 1);
      else if (k <= 5) v = (m_ref + M) % (M + 1);
      else if (k == 6) v = m_ref;
      else if (k <= 8) v = $urandom_range(0, M);
      else             v = $urandom_range(0, 15);
      cycle(en, v, clr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/up_down_count_decoder.md
# up_down_count_decoder

Observer for the looping up/down counter output. It samples a count stream, classifies each step as up, down, hold or illegal, and recovers the counting direction. It reports wrap-around events and direction changes, and keeps a saturating error tally. It sits on the read side of the counter in the emulator, so the DPI-C/JTAG layer can query direction and integrity without re-deriving them in software.

## Interface
- `N`, default 4: count width.
- `MAX_VALUE`, default 10: top of the count loop. Legal range is 2 to 2^N−1; values below 2 make up and down steps indistinguishable.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `clear`  input  1  synchronous flush to empty state; also clears `err_count`.
- `sample_en`  input  1  `count_in` is valid this cycle.
- `count_in`  input  N  observed counter value.
- `dir`  output  1  recovered direction: 1 = up, 0 = down.
- `dir_valid`  output  1  direction is established.
- `last_count`  output  N  most recent accepted sample.
- `step_pulse`  output  1  one-cycle pulse on a legal up or down step.
- `wrap_pulse`  output  1  one-cycle pulse on MAX_VALUE→0 (up) or 0→MAX_VALUE (down).
- `dir_change_pulse`  output  1  one-cycle pulse when a tracked direction reverses.
- `err_pulse`  output  1  one-cycle pulse on an illegal sample.
- `err_count`  output  8  saturating count of illegal samples.

## Operation
- Step classification of new sample `c` against reference `p`:
  - UP: `c == (p==MAX_VALUE ? 0 : p+1)`.
  - DOWN: `c == (p==0 ? MAX_VALUE : p−1)`.
  - HOLD: `c == p`.
  - ILLEGAL: anything else, including any `c > MAX_VALUE`.
- All comparisons are N-bit unsigned. `p+1` and `p−1` are computed at N+1 bits, so there is no silent wrap at 2^N.
- States: EMPTY, PRIMED, UP, DOWN.
- EMPTY:
  - In-range sample: store it and go to PRIMED.
  - Out-of-range sample: raise `err_pulse` and stay in EMPTY.
- PRIMED:
  - UP step → UP state. DOWN step → DOWN state. Neither raises `dir_change_pulse`.
  - HOLD: stay.
  - ILLEGAL: raise `err_pulse` and stay. The new sample becomes the reference if in range; otherwise go to EMPTY.
- UP / DOWN:
  - Same-direction step: stay.
  - Opposite step: move to the other state and raise `dir_change_pulse`.
  - HOLD: stay; no pulses.
  - ILLEGAL: raise `err_pulse`; go to PRIMED if the new sample is in range, else EMPTY.
- Outputs per state:
  - `dir_valid` = 1 in UP and DOWN only.
  - `dir` = 1 in UP, 0 in DOWN, and holds its last value elsewhere.
- `step_pulse` accompanies every UP or DOWN classification, including the first one from PRIMED. `wrap_pulse` is always a subset of `step_pulse`.
- `err_count` increments on each `err_pulse` and saturates at 255.
- `last_count` updates on every in-range accepted sample.

## Timing
- All outputs are registered. Response appears in the cycle after the `sample_en` edge (1-cycle latency).
- Pulses are high for exactly one cycle. Back-to-back samples produce back-to-back pulses.
- If `sample_en` is low, state, `last_count`, `dir` and `dir_valid` hold, and all pulses are 0.
- `clear` has priority over `sample_en` in the same cycle; that sample is discarded. After `clear`: EMPTY, `err_count` = 0, pulses = 0, `dir`/`last_count` = 0.
- Reset (asserted asynchronously, at any time including mid-stream): state EMPTY; every output is 0, including `dir`, `dir_valid`, `last_count` and `err_count`.
- Reset release is synchronous to `clk`. The first sample after release is treated as a reference only.

## Structure
- Package `up_down_counter_pkg` holds:
  - state enum `ud_state_t` {EMPTY, PRIMED, UP, DOWN};
  - step enum `ud_step_t` {STEP_UP, STEP_DOWN, STEP_HOLD, STEP_ILLEGAL};
  - constant `ERR_CNT_W` = 8.
- Sub-module `up_down_step_classify`: purely combinational, parameterised by `N`/`MAX_VALUE`. Inputs `p`, `c`; outputs `ud_step_t` and an is-wrap flag.
- The top level holds the FSM, the registers and the error counter.

## Test plan
Defaults N=4, MAX_VALUE=10.
- Up run with wrap: after reset, samples 8,9,10,0,1.
  - Required: `dir_valid` = 1 and `dir` = 1 from the second response.
  - `step_pulse` on each of the 4 steps.
  - `wrap_pulse` only on 10→0.
  - `err_count` = 0.
- Down run with wrap and reversal: samples 1,0,10,9,10.
  - Required: `wrap_pulse` on 0→10, `dir` = 0 then `dir` = 1.
  - `dir_change_pulse` exactly once, on 9→10.
- Hold and gaps: samples 3,3,4 with `sample_en` low for 5 cycles between them.
  - Required: no pulses on hold or idle cycles.
  - `step_pulse` once; UP state entered on 3→4.
- Illegal: while tracking UP at 5, sample 9, then 10.
  - Required: `err_pulse` on 9 and state PRIMED.
  - `last_count` = 9; the 9→10 step is UP, so UP state and `dir_valid` = 1 again.
- Out of range and saturation: sample 14 from EMPTY.
  - Required: `err_pulse` and state stays EMPTY.
  - After 300 alternating illegal samples, `err_count` = 255.
  - Asserting `clear` together with `sample_en` gives `err_count` = 0, state EMPTY, and the sample is ignored.
- Async reset mid-stream: drop `reset_n` between clock edges while tracking DOWN.
  - Required: all outputs 0 immediately.
  - The first post-release sample produces no pulses.
